// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the reset domains it controls (slave).
// Handshake: after stage_rst_n[i] rises, stage i raises the level stage_ack[i] when ready; it is
// sampled every clk edge while that stage is awaited, and a later drop is ignored.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  localparam int IDX_W = $clog2(NUM_STAGES) + 1;

  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  busy;
  logic                  err;
  logic [IDX_W-1:0]      err_stage;
  logic [1:0]            dbg_state;

  modport master (
    input  sw_rst_req, stage_ack,
    output stage_rst_n, seq_done, busy, err, err_stage, dbg_state
  );

  modport slave (
    output sw_rst_req, stage_ack,
    input  stage_rst_n, seq_done, busy, err, err_stage, dbg_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order, each after a fixed hold delay and
// gated by the previous stage's ready ack; supports software re-reset and ack timeouts.
module reset_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_DLY     = 16,
  parameter int ACK_TIMEOUT   = 64,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  reset_sequencer_if.master   bus
);
  localparam int IDX_W   = $clog2(NUM_STAGES) + 1;
  localparam int MAX_A   = (STAGE_DLY > ACK_TIMEOUT) ? STAGE_DLY : ACK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > SW_RST_CYCLES) ? MAX_A : SW_RST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_ACK  = 2'd1,
    DONE      = 2'd2,
    SW_ASSERT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
  logic                  seq_done_q, seq_done_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;
  logic                  ack_cur;
  logic                  advance;

  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) ack_cur = bus.stage_ack[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HOLD;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      err_q         <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_rst_n_q <= stage_rst_n_d;
      seq_done_q    <= seq_done_d;
      err_q         <= err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    stage_rst_n_d = stage_rst_n_q;
    seq_done_d    = seq_done_q;
    err_d         = err_q;
    err_stage_d   = err_stage_q;
    advance       = 1'b0;

    case (state_q)
      HOLD: begin
        if (cnt_q == DLY_LAST) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) stage_rst_n_d[i] = 1'b1;
          end
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_ACK: begin
        // A timeout is treated exactly like an ack; only the first offender is recorded.
        if (ack_cur) begin
          advance = 1'b1;
        end else if (ACK_TIMEOUT > 0) begin
          if (cnt_q == ACK_LAST) begin
            advance = 1'b1;
            if (!err_q) begin
              err_d       = 1'b1;
              err_stage_d = idx_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (advance) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d    = DONE;
            seq_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = HOLD;
          end
        end
      end

      DONE: begin
        if (bus.sw_rst_req) begin
          state_d       = SW_ASSERT;
          stage_rst_n_d = '0;
          seq_done_d    = 1'b0;
          err_d         = 1'b0;
          err_stage_d   = '0;
          cnt_d         = '0;
        end
      end

      SW_ASSERT: begin
        if (cnt_q == SW_LAST) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = HOLD;
    endcase
  end

  assign bus.stage_rst_n = stage_rst_n_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.busy        = (state_q != DONE);
  assign bus.err         = err_q;
  assign bus.err_stage   = err_stage_q;
  assign bus.dbg_state   = state_q;
endmodule
